// File: rtl/sr_cond_pkg.sv
// Shared types for the SR input conditioner: FSM state encoding and debounce counter width.
package sr_cond_pkg;
  localparam int CNT_W = 8;
  localparam int PCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SET_P    = 2'd1,
    RST_P    = 2'd2,
    WAIT_REL = 2'd3
  } state_e;
endpackage

// File: rtl/sr_debounce.sv
// One input channel: 2-flop synchronizer followed by a consecutive-sample debouncer.
module sr_debounce
  import sr_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic stb_o
);
  logic             sync1_q, sync2_q;
  logic             stb_q, stb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      stb_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      stb_q   <= stb_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any sample that agrees with the current level restarts the count.
  always_comb begin
    stb_d = stb_q;
    cnt_d = '0;
    if (sync2_q != stb_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign stb_o = stb_q;
endmodule

// File: rtl/sr_input_cond.sv
// Debounces set/reset requests and emits mutually exclusive s/r pulses for a downstream SR latch.
// Define SR_SET_PRIORITY_EN to let set win when both requests arrive together.
module sr_input_cond
  import sr_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_LEN       = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s_raw,
  input  logic r_raw,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);
  logic s_stb, r_stb;
  state_e state_q, state_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic s_q, s_d, r_q, r_d, busy_q, busy_d, conf_q, conf_d;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_s (
    .clk(clk), .rst_n(rst_n), .raw_i(s_raw), .stb_o(s_stb)
  );
  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
    .clk(clk), .rst_n(rst_n), .raw_i(r_raw), .stb_o(r_stb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      busy_q  <= 1'b0;
      conf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      s_q     <= s_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      conf_q  <= conf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (s_stb && r_stb) begin
`ifdef SR_SET_PRIORITY_EN
          state_d = SET_P;
`else
          state_d = WAIT_REL;
`endif
        end else if (s_stb) begin
          state_d = SET_P;
        end else if (r_stb) begin
          state_d = RST_P;
        end
      end
      SET_P, RST_P: begin
        if (pcnt_q == PCNT_W'(PULSE_LEN - 1)) state_d = WAIT_REL;
        else pcnt_d = pcnt_q + 1'b1;
      end
      WAIT_REL: begin
        if (!s_stb && !r_stb) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land in flops aligned with the state.
  always_comb begin
    s_d    = (state_d == SET_P);
    r_d    = (state_d == RST_P);
    busy_d = (state_d != IDLE);
    conf_d = (state_q == IDLE) && s_stb && r_stb;
  end

  assign s        = s_q;
  assign r        = r_q;
  assign busy     = busy_q;
  assign conflict = conf_q;
endmodule

// File: tb/tb_sr_input_cond.sv
// Directed bench for sr_input_cond: three instances cover default, long-pulse and fast-debounce configs.
module tb_sr_input_cond;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_raw = 1'b0;
  logic r_raw = 1'b0;
  logic a_s, a_r, a_busy, a_conf;
  logic b_s, b_r, b_busy, b_conf;
  logic c_s, c_r, c_busy, c_conf;
  int ncmp = 0;
  int nerr = 0;
  int spulses, rpulses;

`ifdef SR_SET_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  always #5 clk = ~clk;

  sr_input_cond dut_a (
    .clk(clk), .rst_n(rst_n), .s_raw(s_raw), .r_raw(r_raw),
    .s(a_s), .r(a_r), .busy(a_busy), .conflict(a_conf)
  );
  sr_input_cond #(.PULSE_LEN(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_raw(s_raw), .r_raw(r_raw),
    .s(b_s), .r(b_r), .busy(b_busy), .conflict(b_conf)
  );
  sr_input_cond #(.DEBOUNCE_CYCLES(1), .PULSE_LEN(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .s_raw(s_raw), .r_raw(r_raw),
    .s(c_s), .r(c_r), .busy(c_busy), .conflict(c_conf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; s and r must never be high together on any instance.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("excl_a", {31'd0, a_s & a_r}, 32'd0);
    chk("excl_b", {31'd0, b_s & b_r}, 32'd0);
    chk("excl_c", {31'd0, c_s & c_r}, 32'd0);
  endtask

  task automatic do_reset();
    s_raw = 1'b0;
    r_raw = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_s", {31'd0, a_s}, 32'd0);
    chk("rst_r", {31'd0, a_r}, 32'd0);
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    chk("rst_conf", {31'd0, a_conf}, 32'd0);

    // Clean press: pulse on edge 7, busy until 7 edges after release
    do_reset();
    tick();
    chk("post_rst_s", {31'd0, a_s}, 32'd0);
    s_raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("clean_s_%0d", k), {31'd0, a_s}, {31'd0, k == 7});
      chk($sformatf("clean_busy_%0d", k), {31'd0, a_busy}, {31'd0, k >= 7});
      chk($sformatf("clean_r_%0d", k), {31'd0, a_r}, 32'd0);
    end
    s_raw = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("rel_busy_%0d", k), {31'd0, a_busy}, {31'd0, k < 7});
    end

    // Bounce then hold: exactly one pulse, 7 edges after final 0->1
    do_reset();
    tick();
    spulses = 0;
    for (int k = 0; k < 6; k++) begin
      s_raw = (k % 2 == 0);
      tick();
      chk($sformatf("bounce_s_%0d", k), {31'd0, a_s}, 32'd0);
    end
    s_raw = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (a_s) spulses++;
      chk($sformatf("bhold_s_%0d", k), {31'd0, a_s}, {31'd0, k == 7});
    end
    chk("bounce_npulse", spulses, 32'd1);

    // Simultaneous requests
    do_reset();
    tick();
    s_raw = 1'b1;
    r_raw = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("sim_conf_%0d", k), {31'd0, a_conf}, {31'd0, k == 7});
      chk($sformatf("sim_s_%0d", k), {31'd0, a_s}, {31'd0, PRIO && k == 7});
      chk($sformatf("sim_r_%0d", k), {31'd0, a_r}, 32'd0);
      chk($sformatf("sim_busy_%0d", k), {31'd0, a_busy}, {31'd0, k >= 7});
    end

    // Requests held through WAIT_REL are not served
    do_reset();
    tick();
    spulses = 0;
    rpulses = 0;
    for (int k = 0; k < 48; k++) begin
      if (k == 0)  s_raw = 1'b1;
      if (k == 12) r_raw = 1'b1;
      if (k == 24) s_raw = 1'b0;
      if (k == 36) r_raw = 1'b0;
      tick();
      if (a_s) spulses++;
      if (a_r) rpulses++;
    end
    chk("wait_spulses", spulses, 32'd1);
    chk("wait_rpulses", rpulses, 32'd0);
    chk("wait_busy_end", {31'd0, a_busy}, 32'd0);

    // Reset mid-pulse on the 4-cycle instance
    do_reset();
    tick();
    s_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("mid_s_%0d", k), {31'd0, b_s}, {31'd0, k >= 7});
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_s", {31'd0, b_s}, 32'd0);
    chk("mid_rst_busy", {31'd0, b_busy}, 32'd0);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("mid_re_s_%0d", k), {31'd0, b_s}, {31'd0, k >= 7 && k <= 10});
    end

    // Fast debounce, 3-cycle reset pulse starting edge 4
    do_reset();
    tick();
    r_raw = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("fast_r_%0d", k), {31'd0, c_r}, {31'd0, k >= 4 && k <= 6});
      chk($sformatf("fast_s_%0d", k), {31'd0, c_s}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/sr_input_cond.md
SR_INPUT_COND -- requirements
Module: sr_input_cond

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples (range 1..255) required to accept a raw input change.
REQ-002 Parameter PULSE_LEN, default 1, number of cycles each s/r output pulse is held high (range 1..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 s_raw  input  1  asynchronous, bouncy set request (e.g. push button).
REQ-006 r_raw  input  1  asynchronous, bouncy reset request.
REQ-007 s  output  1  registered set pulse, drives the downstream SR latch s input.
REQ-008 r  output  1  registered reset pulse, drives the downstream SR latch r input.
REQ-009 busy  output  1  high whenever FSM is not in IDLE.
REQ-010 conflict  output  1  one-cycle pulse when both debounced requests assert in the same cycle.

Function
REQ-011 Each raw input passes through a 2-flop synchronizer, then a debouncer; the debounced level (s_stb/r_stb) changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from the current s_stb/r_stb.
REQ-012 Debounce counter clears to 0 on any synchronized sample equal to the current s_stb/r_stb level (bounce restarts the count).
REQ-013 FSM states: IDLE, SET_P, RST_P, WAIT_REL.
REQ-014 IDLE: s_stb=1,r_stb=0 -> SET_P; r_stb=1,s_stb=0 -> RST_P; both 1 -> conflict pulse, then behaviour per REQ-024/025; neither -> stay.
REQ-015 SET_P/RST_P: hold s (resp. r) high exactly PULSE_LEN cycles, then -> WAIT_REL.
REQ-016 WAIT_REL: stay until s_stb=0 and r_stb=0 in the same cycle, then -> IDLE; requests asserted while in WAIT_REL are not served.
REQ-017 Latency: a clean s_raw 0->1 held steady makes s go high on the (DEBOUNCE_CYCLES+3)th rising edge after the first edge that samples s_raw=1 (7th for default); same for r.
REQ-018 s and r are never high in the same cycle under any input sequence.
REQ-019 One pulse per debounced assertion; holding a raw input high indefinitely yields exactly one pulse.
REQ-020 busy is high in SET_P, RST_P, WAIT_REL; low in IDLE.

Reset
REQ-021 rst_n=0 asynchronously forces s=0, r=0, busy=0, conflict=0, FSM=IDLE, synchronizer flops=0, s_stb=r_stb=0, counters=0.
REQ-022 Reset asserted mid-pulse terminates the pulse immediately; after release, a still-held raw input is re-debounced from zero and produces a fresh pulse.
REQ-023 Outputs are deterministic in the first cycle after rst_n deasserts (no pulse before full debounce latency).

Configuration
REQ-024 Without SR_SET_PRIORITY_EN: simultaneous s_stb=r_stb=1 in IDLE -> conflict pulse, no s/r pulse, FSM -> WAIT_REL.
REQ-025 With SR_SET_PRIORITY_EN defined: simultaneous case -> conflict pulse and FSM -> SET_P (set wins); all other behaviour unchanged.

Structure
REQ-026 Package sr_cond_pkg holds the FSM state enum (2-bit) and the debounce counter width constant (8 bits).
REQ-027 One sub-module sr_debounce (synchronizer + counter + stable level), instantiated twice (set and reset channel).
REQ-028 Total RTL 120-400 lines; no latches inferred; all outputs come directly from flops.

Verification
REQ-029 Clean press: s_raw 0->1 held 20 cycles, defaults -> s high on edge 7 for 1 cycle, busy high edges 7..release+~7, r stays 0.
REQ-030 Bounce: s_raw toggles every cycle for 6 cycles then holds 1 -> exactly one s pulse, 7 edges after the final stable transition.
REQ-031 Simultaneous: s_raw,r_raw 0->1 same cycle -> conflict pulse once; s=r=0 without macro; s pulse, r=0 with SR_SET_PRIORITY_EN.
REQ-032 Held-during-wait: s pressed, then r pressed while s held, s released, r released -> one s pulse only, no r pulse.
REQ-033 Reset mid-pulse with PULSE_LEN=4: rst_n low on pulse cycle 2 -> s=0 same cycle; s_raw still high after release -> new s pulse 7 edges later.
REQ-034 PULSE_LEN=3, DEBOUNCE_CYCLES=1: r press -> r high exactly 3 cycles starting edge 4; scoreboard checks s&r never 1.
